// File: rtl/serial_alu_pkg.sv
// ---------------------------------------------------------------------------
// serial_alu_pkg
// Shared definitions for the bit-serial ALU and its 1-bit slice:
//   - ALU_control codes seen at the serial_alu boundary
//   - 2-bit operation codes understood by alu_bit_slice
//   - FSM state encoding of the serial sequencer
// ---------------------------------------------------------------------------
package serial_alu_pkg;

    // ALU_control = {A_invert, B_invert, op[1:0]}
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;

    // Operation codes of the 1-bit slice
    localparam logic [1:0] SLICE_AND = 2'd0;
    localparam logic [1:0] SLICE_OR  = 2'd1;
    localparam logic [1:0] SLICE_ADD = 2'd2;
    localparam logic [1:0] SLICE_SLT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // True when the slice must produce a carry for this op code
    function automatic logic slice_has_carry(input logic [1:0] op);
        return (op == SLICE_ADD) || (op == SLICE_SLT);
    endfunction

endpackage

// File: rtl/serial_alu_bit_slice.sv
// ---------------------------------------------------------------------------
// alu_bit_slice
// Combinational 1-bit ALU slice.
//   a, b       : operand bits
//   a_invert   : invert a before use
//   b_invert   : invert b before use
//   cin        : carry in
//   op[1:0]    : SLICE_AND / SLICE_OR / SLICE_ADD / SLICE_SLT
//   result     : logic bit or sum bit (SLT also yields the sum bit; the
//                set decision is made by the sequencer at the MSB)
//   cout       : carry out for ADD/SLT, 0 for logic ops
// ---------------------------------------------------------------------------
module alu_bit_slice
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       result,
    output logic       cout
);

    logic a_eff;
    logic b_eff;
    logic sum;

    assign a_eff = a ^ a_invert;
    assign b_eff = b ^ b_invert;
    assign sum   = a_eff ^ b_eff ^ cin;

    always_comb begin
        result = 1'b0;
        case (op)
            SLICE_AND: result = a_eff & b_eff;
            SLICE_OR:  result = a_eff | b_eff;
            SLICE_ADD: result = sum;
            SLICE_SLT: result = sum;
            default:   result = 1'b0;
        endcase
    end

    assign cout = slice_has_carry(op) &
                  ((a_eff & b_eff) | (a_eff & cin) | (b_eff & cin));

endmodule

// File: rtl/serial_alu.sv
// ---------------------------------------------------------------------------
// serial_alu
// Bit-serial WIDTH-bit ALU: one result bit per clock through alu_bit_slice,
// LSB first, with the carry fed back through a 1-bit register.
//   clk, rst_n    : clock (rising edge), synchronous active-low reset
//   start         : request, only sampled in IDLE
//   ALU_control   : {A_invert, B_invert, op[1:0]}, latched with start
//   src1, src2    : operands, latched with start
//   busy          : high while an operation is in SHIFT/DONE
//   done          : one-cycle pulse, result fields valid
//   result, zero  : registered result and result==0, held until next done
//   cout          : MSB carry-out for ADD/SUB/SLT, else 0
//   overflow      : signed overflow for ADD/SUB, else 0
// ---------------------------------------------------------------------------
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e state;
    state_e next_state;
    logic   accept;
    logic   last_bit;

    logic [CW-1:0]    cnt;
    logic             carry;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             c_in_msb;
    logic             cout_msb;
    logic             sum_msb;

    logic [1:0] slice_op;
    logic       slice_res;
    logic       slice_cout;

    logic [WIDTH-1:0] fin_result;
    logic             fin_cout;
    logic             fin_ovf;
    logic             slt_set;

    // SLT runs the adder with B inverted; the set bit is resolved at the MSB
    assign slice_op = (ctrl == ALU_SLT) ? SLICE_ADD : ctrl[1:0];
    assign last_bit = (cnt == LAST_BIT);

    alu_bit_slice u_slice (
        .a        (a_sr[0]),
        .b        (b_sr[0]),
        .a_invert (ctrl[3]),
        .b_invert (ctrl[2]),
        .cin      (carry),
        .op       (slice_op),
        .result   (slice_res),
        .cout     (slice_cout)
    );

    // ---- FSM state register ----
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // ---- FSM next state ----
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: if (last_bit) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // ---- control: counter, carry, output registers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                cnt   <= '0;
                carry <= ALU_control[2];   // B_invert supplies the +1 of two's complement
                busy  <= 1'b1;
            end else if (state == ST_SHIFT) begin
                if (!last_bit) cnt <= cnt + 1'b1;
                carry <= slice_cout;
            end else if (state == ST_DONE) begin
                busy     <= 1'b0;
                done     <= 1'b1;
                result   <= fin_result;
                zero     <= (fin_result == '0);
                cout     <= fin_cout;
                overflow <= fin_ovf;
            end
        end
    end

    // ---- datapath: operand/result shift registers and MSB capture ----
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sr <= src1;
            b_sr <= src2;
            ctrl <= ALU_control;
        end else if (state == ST_SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {slice_res, res_sr[WIDTH-1:1]};
            if (last_bit) begin
                c_in_msb <= carry;
                cout_msb <= slice_cout;
                sum_msb  <= slice_res;
            end
        end
    end

    // ---- result formatting in DONE ----
    // Signed less-than corrected for overflow: sign ^ overflow
    assign slt_set = sum_msb ^ (c_in_msb ^ cout_msb);

    always_comb begin
        fin_result = '0;
        fin_cout   = 1'b0;
        fin_ovf    = 1'b0;
        case (ctrl)
            ALU_ADD, ALU_SUB: begin
                fin_result = res_sr;
                fin_cout   = cout_msb;
                fin_ovf    = c_in_msb ^ cout_msb;
            end
            ALU_SLT: begin
                fin_result = {{(WIDTH-1){1'b0}}, slt_set};
                fin_cout   = cout_msb;
            end
            ALU_AND, ALU_OR, ALU_NOR: fin_result = res_sr;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_alu.sv
// ---------------------------------------------------------------------------
// tb_serial_alu
// Self-checking bench for serial_alu (WIDTH=32) with an arithmetic
// reference model.
// ---------------------------------------------------------------------------
module tb_serial_alu;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [3:0]   ALU_control;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         cout;
    logic         overflow;

    int checks;
    int failures;

    serial_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ALU_control (ALU_control),
        .src1        (src1),
        .src2        (src2),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .cout        (cout),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from the arithmetic meaning of each code
    function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic z, output logic co,
                                  output logic ov);
        logic [W:0] t;
        r  = '0;
        co = 1'b0;
        ov = 1'b0;
        case (c)
            4'b0010: begin
                t  = {1'b0, a} + {1'b0, b};
                r  = t[W-1:0];
                co = t[W];
                ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0110: begin
                r  = a - b;
                co = (a >= b);
                ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'b0111: begin
                r  = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
                co = (a >= b);
            end
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            default: r = '0;
        endcase
        z = (r == '0);
    endfunction

    // Issue one operation from IDLE and wait (bounded) for done.
    // With disturb set, operands/control are scrambled and start toggled
    // randomly while the operation is in flight.
    task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit disturb, output logic [W-1:0] r, output logic z,
                          output logic co, output logic ov, output int lat, output logic busy0);
        ALU_control = c;
        src1        = a;
        src2        = b;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy0 = busy;
        lat   = 0;
        r     = '0;
        z     = 1'b0;
        co    = 1'b0;
        ov    = 1'b0;
        while (lat < 200) begin
            if (disturb) begin
                src1        = $urandom;
                src2        = $urandom;
                ALU_control = 4'($urandom);
                start       = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
            if (done) begin
                start = 1'b0;
                r  = result;
                z  = zero;
                co = cout;
                ov = overflow;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        start       = 1'b0;
        ALU_control = 4'b0010;
        src1        = '0;
        src2        = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, zero, cout, overflow} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got busy/done/zero/cout/ovf=%b want 00000",
                     {busy, done, zero, cout, overflow});
        end
        checks++;
        if (result !== '0) begin
            failures++;
            $display("FAIL reset_result got %h want 0", result);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [3:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] er;
        logic         ez;
        logic         ec;
        logic         ev;
    } vec_t;

    task automatic test_directed;
        vec_t v[8];
        logic [W-1:0] r;
        logic z, co, ov, b0;
        int lat;
        v[0] = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
        v[1] = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0};
        v[2] = '{4'b0111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0};
        v[3] = '{4'b0111, 32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
        v[4] = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        v[5] = '{4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
        v[6] = '{4'b1100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0, 1'b0};
        v[7] = '{4'b0101, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            run_op(v[i].c, v[i].a, v[i].b, 1'b0, r, z, co, ov, lat, b0);
            checks++;
            if (lat !== LAT) begin
                failures++;
                $display("FAIL directed%0d_latency got %0d want %0d", i, lat, LAT);
            end
            checks++;
            if ({r, z, co, ov} !== {v[i].er, v[i].ez, v[i].ec, v[i].ev}) begin
                failures++;
                $display("FAIL directed%0d_ctrl%b got r=%h z=%b c=%b v=%b want r=%h z=%b c=%b v=%b",
                         i, v[i].c, r, z, co, ov, v[i].er, v[i].ez, v[i].ec, v[i].ev);
            end
            checks++;
            if (b0 !== 1'b1) begin
                failures++;
                $display("FAIL directed%0d_busy_after_accept got %b want 1", i, b0);
            end
        end
    endtask

    task automatic test_random(input bit disturb);
        logic [3:0] codes[8];
        logic [W-1:0] a, b, r, er;
        logic z, co, ov, ez, ec, ev, b0;
        logic [3:0] c;
        int lat;
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0101, 4'b1111};
        for (int i = 0; i < 30; i++) begin
            c = codes[$urandom_range(0, 7)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = {1'b1, {(W-1){1'b0}}};
            if ($urandom_range(0, 3) == 0) b = {1'b0, {(W-1){1'b1}}};
            if ($urandom_range(0, 5) == 0) b = a;
            model(c, a, b, er, ez, ec, ev);
            run_op(c, a, b, disturb, r, z, co, ov, lat, b0);
            checks++;
            if ({r, z, co, ov, lat} !== {er, ez, ec, ev, LAT}) begin
                failures++;
                $display("FAIL random%0d_d%0d ctrl=%b a=%h b=%h got r=%h z=%b c=%b v=%b lat=%0d want r=%h z=%b c=%b v=%b lat=%0d",
                         i, disturb, c, a, b, r, z, co, ov, lat, er, ez, ec, ev, LAT);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a1, b1, a2, b2, er1, er2;
        logic ez, ec, ev;
        int lat;
        int t_done1;
        int t_done2;
        logic [W-1:0] r1, r2;
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = $urandom;
        model(4'b0010, a1, b1, er1, ez, ec, ev);
        model(4'b0110, a2, b2, er2, ez, ec, ev);
        t_done1 = -1;
        t_done2 = -1;
        r1 = '0;
        r2 = '0;
        ALU_control = 4'b0010;
        src1        = a1;
        src2        = b1;
        start       = 1'b1;
        @(posedge clk); #1;
        // start stays high; second op's operands wait on the inputs
        ALU_control = 4'b0110;
        src1        = a2;
        src2        = b2;
        lat = 0;
        while (lat < 150 && t_done2 < 0) begin
            @(posedge clk); #1;
            lat++;
            if (done) begin
                if (t_done1 < 0) begin
                    t_done1 = lat;
                    r1      = result;
                end else begin
                    t_done2 = lat;
                    r2      = result;
                    start   = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (t_done1 !== LAT || r1 !== er1) begin
            failures++;
            $display("FAIL b2b_first got t=%0d r=%h want t=%0d r=%h", t_done1, r1, LAT, er1);
        end
        checks++;
        if (t_done2 - t_done1 !== W + 2 || r2 !== er2) begin
            failures++;
            $display("FAIL b2b_second got gap=%0d r=%h want gap=%0d r=%h",
                     t_done2 - t_done1, r2, W + 2, er2);
        end
        // drain until idle with start low
        repeat (W + 4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] r, er;
        logic z, co, ov, ez, ec, ev, b0;
        int lat;
        int seen;
        // leave a nonzero result in the output register first
        run_op(4'b0010, 32'h00000001, 32'h00000001, 1'b0, r, z, co, ov, lat, b0);
        ALU_control = 4'b0010;
        src1        = 32'h0000FFFF;
        src2        = 32'h00000001;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00 || result !== '0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (W + 5) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_done got %0d done pulses want 0", seen);
        end
        model(4'b0110, 32'h00000003, 32'h00000007, er, ez, ec, ev);
        run_op(4'b0110, 32'h00000003, 32'h00000007, 1'b0, r, z, co, ov, lat, b0);
        checks++;
        if ({r, z, co, ov, lat} !== {er, ez, ec, ev, LAT}) begin
            failures++;
            $display("FAIL reset_mid_after got r=%h z=%b c=%b v=%b lat=%0d want r=%h z=%b c=%b v=%b lat=%0d",
                     r, z, co, ov, lat, er, ez, ec, ev, LAT);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_random(1'b0);
        test_random(1'b1);
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
